// File: rtl/shift_add_multiplier.sv
// Iterative radix-2 shift-and-add multiplier, signed or unsigned, one bit per cycle.
// Start/ready/done responder for the execute stage; product is registered and held.
module shift_add_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               m_signed,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  typedef struct packed {
    logic             sgn;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
  } req_t;

  state_t             state, state_nxt;
  req_t               req;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic               accept;
  logic               last;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_nxt;

  // The most-negative input negates to itself, which read unsigned is its true magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    mag = (s && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  assign accept = (state == IDLE) && start;
  assign last   = (cnt == CW'(WIDTH-1));

  // Carry of the WIDTH+1 bit add becomes the new accumulator MSB after the shift.
  assign sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (req.mplier[0] ? {1'b0, req.mcand} : '0);
  assign acc_nxt = {sum, acc[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    done  = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req     <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      req.sgn    <= m_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
      req.mcand  <= mag(src_a, m_signed);
      req.mplier <= mag(src_b, m_signed);
      acc        <= '0;
      cnt        <= '0;
    end else if (state == BUSY) begin
      acc        <= acc_nxt;
      req.mplier <= req.mplier >> 1;
      cnt        <= cnt + CW'(1);
      if (last) product <= req.sgn ? (~acc_nxt + (2*WIDTH)'(1)) : acc_nxt;
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: vector table plus isolation and reset-abort sequences.
module tb_shift_add_multiplier;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           m_signed;
  logic [W-1:0]   src_a, src_b;
  logic           ready, done;
  logic [2*W-1:0] product;

  int total = 0;
  int bad   = 0;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .m_signed(m_signed),
    .src_a(src_a), .src_b(src_b), .ready(ready), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  always @(negedge clk) if (reset) chk("ready_done_exclusive", 64'(ready & done), 64'd0);

  typedef struct {
    logic           sgn;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Start one multiply from IDLE and return the product and cycles from accept to done.
  task automatic run_mul(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [2*W-1:0] res, output int lat, output int ok);
    int n;
    n = 0;
    while (!ready && n < 100) begin tick(); n++; end
    m_signed = sgn; src_a = a; src_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ready_falls", 64'(ready), 64'd0);
    lat = 0;
    while (!done && lat < 100) begin tick(); lat++; end
    ok  = done;
    res = product;
  endtask

  initial begin
    logic [2*W-1:0] res;
    int lat, ok, dones, held;

    reset = 1'b0; start = 1'b0; m_signed = 1'b0; src_a = '0; src_b = '0;
    vecs[0] = '{1'b0, 32'd3,        32'd5,        64'h00000000_0000000F};
    vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'd6,        64'hFFFFFFFF_FFFFFFD6};
    vecs[2] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    vecs[3] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};
    vecs[4] = '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    vecs[5] = '{1'b1, 32'h80000000, 32'd1,        64'hFFFFFFFF_80000000};
    vecs[6] = '{1'b0, 32'h80000000, 32'd2,        64'h00000001_00000000};
    vecs[7] = '{1'b0, 32'hFFFFFFFF, 32'd2,        64'h00000001_FFFFFFFE};
    vecs[8] = '{1'b1, 32'd7,        32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB};
    vecs[9] = '{1'b1, 32'd0,        32'h80000000, 64'h00000000_00000000};

    repeat (3) tick();
    chk("reset_ready",   64'(ready), 64'd1);
    chk("reset_done",    64'(done),  64'd0);
    chk("reset_product", product,    64'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_mul(vecs[i].sgn, vecs[i].a, vecs[i].b, res, lat, ok);
      chk($sformatf("vec%0d_done_seen", i), 64'(ok), 64'd1);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
      chk($sformatf("vec%0d_product", i), res, vecs[i].exp);
      tick();
      chk($sformatf("vec%0d_done_one_cycle", i), 64'(done), 64'd0);
      chk($sformatf("vec%0d_ready_back", i), 64'(ready), 64'd1);
      chk($sformatf("vec%0d_product_hold", i), product, vecs[i].exp);
    end

    // Operand churn and stray starts while a 9*9 is in flight.
    m_signed = 1'b0; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0; lat = 0;
    while (!done && lat < 100) begin
      src_a = $urandom; src_b = $urandom;
      if (lat == 5) begin src_a = 32'd2; src_b = 32'd2; start = 1'b1; end
      else start = 1'b0;
      tick(); lat++;
    end
    start = 1'b0;
    chk("iso_latency", 64'(lat), 64'd32);
    chk("iso_product", product, 64'd81);
    src_a = 32'd2; src_b = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("iso_ready_after_done", 64'(ready), 64'd1);
    chk("iso_single_done", 64'(done), 64'd0);
    src_a = 32'd4; src_b = 32'd4; start = 1'b1;
    tick();
    start = 1'b0; src_a = 32'd7; src_b = 32'd7;
    held = 1; lat = 0;
    while (!done && lat < 100) begin
      if (product !== 64'd81) held = 0;
      tick(); lat++;
    end
    chk("iso_81_held", 64'(held), 64'd1);
    chk("iso2_latency", 64'(lat), 64'd32);
    chk("iso2_product", product, 64'd16);
    tick();

    // Asynchronous abort in the middle of BUSY.
    src_a = 32'd100; src_b = 32'd100; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2 reset = 1'b0;
    #1;
    chk("abort_ready",   64'(ready), 64'd1);
    chk("abort_done",    64'(done),  64'd0);
    chk("abort_product", product,    64'd0);
    tick();
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 50; i++) begin
      if (done) dones++;
      tick();
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    chk("abort_product_kept", product, 64'd0);
    run_mul(1'b0, 32'd2, 32'd3, res, lat, ok);
    chk("post_abort_latency", 64'(lat), 64'd32);
    chk("post_abort_product", res, 64'd6);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
